dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single data-memory port (m_addr/m_rw_/write_data/read_data) between two
//   requesters: port 0 (CPU load/store stage) and port 1 (DMA/debug loader). Grants one
//   request at a time, models memory access time with programmable wait states, returns
//   read data and a one-cycle ack. Sits between the requesters and the data memory.
// PARAMETERS
//   ADDRSIZE     12  address width, matches data memory
//   WIDTH        32  data width
//   WAIT_CYCLES  2   extra access cycles before completion (0..15)
//   FIXED_PRIO   0   0 = round-robin; 1 = port 0 always wins ties
// PORTS
//   clk          in   1         system clock, all state on rising edge
//   rst          in   1         asynchronous, active-high reset
//   req0/req1    in   1         access request, held until ackN
//   rw0/rw1      in   1         1 = write, 0 = read (same sense as m_rw_)
//   addr0/addr1  in   ADDRSIZE  word address
//   wdata0/1     in   WIDTH     write data
//   ack0/ack1    out  1         one-cycle completion pulse
//   rdata0/1     out  WIDTH     read result, valid from ackN until next read completes on that port
//   busy         out  1         1 when state != IDLE
//   m_addr       out  ADDRSIZE  to memory address
//   m_rw_        out  1         to memory; 1 = write on this clk edge
//   write_data   out  WIDTH     to memory write data
//   read_data    in   WIDTH     from memory, combinational read of m_addr
// BEHAVIOUR
//   - Reset values: state IDLE, m_addr 0, m_rw_ 0, write_data 0, ack0/1 0, rdata0/1 0,
//     busy 0, last_grant = 1 (port 0 wins first tie), wait counter 0.
//   - FSM: IDLE -> ACCESS -> RESP -> IDLE.
//   - IDLE: if any req, pick winner; latch addr/rw/wdata into m_addr/rw_q/write_data;
//     cnt <= WAIT_CYCLES; go ACCESS. No req: stay.
//   - Arbitration: single req wins. Both: FIXED_PRIO=1 -> port 0; else the port not equal
//     to last_grant. last_grant <= winner on every grant.
//   - ACCESS: m_addr/write_data stable. cnt != 0: cnt <= cnt-1, m_rw_ = 0.
//     cnt == 0 (final cycle): m_rw_ = rw_q (memory writes exactly once, on this edge);
//     for reads, capture read_data into rdata of winner; go RESP.
//   - RESP: ackN = 1 for winner only, one cycle; go IDLE. req ignored in RESP.
//   - Latency: req seen in IDLE at edge T -> ack high in cycle T+WAIT_CYCLES+2.
//     Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.
//   - Requester drops req on the edge where it samples ack; req still high in IDLE after
//     ack is a new request. req dropped mid-ACCESS does not abort (request latched).
//   - rdata not updated by writes; other port's rdata never touched.
//   - m_rw_ decoded from registered state only (no glitch from req inputs); never 1
//     outside the final ACCESS cycle.
//   - Reset mid-ACCESS: immediate return to IDLE, m_rw_ forced 0 asynchronously, no
//     write issued, no ack; requester reissues.
// TESTING
//   1 WAIT=2, mem[5]=0xA5A5_0001; req0 read addr 5 at T -> ack0 at T+4, rdata0=0xA5A5_0001, ack1 never.
//   2 port1 write 0xDEAD_BEEF to addr 9, then port0 read 9 -> m_rw_ high exactly 1 cycle, rdata0=0xDEAD_BEEF.
//   3 RR: req0 and req1 held high, 4 accesses -> grants 0,1,0,1; busy low only 1 cycle between.
//   4 FIXED_PRIO=1, both held continuously -> port 0 granted every time, ack1 never fires.
//   5 rst pulsed during ACCESS of a write to addr 3 -> mem[3] unchanged, no ack, outputs at reset values.
//   6 WAIT_CYCLES=0: read addr 0 -> ack at T+2; req dropped after ACCESS entry still completes.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data-memory port, with programmable
// wait states, round-robin or fixed-priority tie breaking and a one-cycle ack.
module dmem_arbiter #(
  parameter int ADDRSIZE    = 12,
  parameter int WIDTH       = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int FIXED_PRIO  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic                rw0,
  input  logic                rw1,
  input  logic [ADDRSIZE-1:0] addr0,
  input  logic [ADDRSIZE-1:0] addr1,
  input  logic [WIDTH-1:0]    wdata0,
  input  logic [WIDTH-1:0]    wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic [WIDTH-1:0]    rdata0,
  output logic [WIDTH-1:0]    rdata1,
  output logic                busy,
  output logic [ADDRSIZE-1:0] m_addr,
  output logic                m_rw_,
  output logic [WIDTH-1:0]    write_data,
  input  logic [WIDTH-1:0]    read_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic                win_q, win_d;
  logic                lastGrant_q, lastGrant_d;
  logic [ADDRSIZE-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [WIDTH-1:0]    rdata0_q, rdata0_d;
  logic [WIDTH-1:0]    rdata1_q, rdata1_d;
  logic                winner;

  // On a tie, round-robin hands the grant to whichever port did not win last.
  always_comb begin
    if (req0 && req1) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~lastGrant_q;
    end else begin
      winner = req1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    win_d       = win_q;
    lastGrant_d = lastGrant_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d       = winner;
          lastGrant_d = winner;
          addr_d      = winner ? addr1 : addr0;
          rw_d        = winner ? rw1 : rw0;
          wdata_d     = winner ? wdata1 : wdata0;
          cnt_d       = WAIT_INIT;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!rw_q) begin
            if (win_q) rdata1_d = read_data;
            else       rdata0_d = read_data;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rw_q        <= 1'b0;
      win_q       <= 1'b0;
      lastGrant_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      win_q       <= win_d;
      lastGrant_q <= lastGrant_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Memory strobe comes only from registered state, so reset drops it at once.
  assign m_rw_      = (state_q == ACCESS) && (cnt_q == 4'd0) && rw_q;
  assign busy       = (state_q != IDLE);
  assign ack0       = (state_q == RESP) && !win_q;
  assign ack1       = (state_q == RESP) && win_q;
  assign m_addr     = addr_q;
  assign write_data = wdata_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: instance A is round-robin with two wait states, instance B is
// fixed-priority with no wait states; each has its own behavioural memory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic preload;

  logic        aReq0, aReq1, aRw0, aRw1, aAck0, aAck1, aBusy, aMrw;
  logic [11:0] aAddr0, aAddr1, aMaddr;
  logic [31:0] aWd0, aWd1, aRd0, aRd1, aMwd, aMrd;
  logic        bReq0, bReq1, bRw0, bRw1, bAck0, bAck1, bBusy, bMrw;
  logic [11:0] bAddr0, bAddr1, bMaddr;
  logic [31:0] bWd0, bWd1, bRd0, bRd1, bMwd, bMrd;

  logic [31:0] memA [0:4095];
  logic [31:0] memB [0:4095];

  int errors = 0;
  int checks = 0;
  int aWrCnt = 0;
  int aIdleCnt = 0;
  int bWrCnt = 0;
  int bAck1Cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDRSIZE(12), .WIDTH(32), .WAIT_CYCLES(2), .FIXED_PRIO(0)) dutA (
    .clk(clk), .rst(rst),
    .req0(aReq0), .req1(aReq1), .rw0(aRw0), .rw1(aRw1),
    .addr0(aAddr0), .addr1(aAddr1), .wdata0(aWd0), .wdata1(aWd1),
    .ack0(aAck0), .ack1(aAck1), .rdata0(aRd0), .rdata1(aRd1), .busy(aBusy),
    .m_addr(aMaddr), .m_rw_(aMrw), .write_data(aMwd), .read_data(aMrd)
  );

  dmem_arbiter #(.ADDRSIZE(12), .WIDTH(32), .WAIT_CYCLES(0), .FIXED_PRIO(1)) dutB (
    .clk(clk), .rst(rst),
    .req0(bReq0), .req1(bReq1), .rw0(bRw0), .rw1(bRw1),
    .addr0(bAddr0), .addr1(bAddr1), .wdata0(bWd0), .wdata1(bWd1),
    .ack0(bAck0), .ack1(bAck1), .rdata0(bRd0), .rdata1(bRd1), .busy(bBusy),
    .m_addr(bMaddr), .m_rw_(bMrw), .write_data(bMwd), .read_data(bMrd)
  );

  assign aMrd = memA[aMaddr];
  assign bMrd = memB[bMaddr];

  always @(posedge clk) begin
    if (preload) begin
      memA[3] <= 32'h1111_2222;
      memA[5] <= 32'hA5A5_0001;
      memA[9] <= 32'h0000_0000;
      memB[0] <= 32'hC0FF_EE00;
      memB[1] <= 32'h1000_0001;
      memB[2] <= 32'h2000_0002;
    end else begin
      if (aMrw) memA[aMaddr] <= aMwd;
      if (bMrw) memB[bMaddr] <= bMwd;
    end
  end

  // Event counters sampled mid-cycle, read as deltas by the directed steps.
  always @(negedge clk) begin
    if (aMrw)   aWrCnt   <= aWrCnt + 1;
    if (!aBusy) aIdleCnt <= aIdleCnt + 1;
    if (bMrw)   bWrCnt   <= bWrCnt + 1;
    if (bAck1)  bAck1Cnt <= bAck1Cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit useB, input bit port, input bit req, input bit rw,
                               input logic [11:0] addr, input logic [31:0] wdata);
    if (!useB && !port) begin aReq0 = req; aRw0 = rw; aAddr0 = addr; aWd0 = wdata; end
    if (!useB &&  port) begin aReq1 = req; aRw1 = rw; aAddr1 = addr; aWd1 = wdata; end
    if ( useB && !port) begin bReq0 = req; bRw0 = rw; bAddr0 = addr; bWd0 = wdata; end
    if ( useB &&  port) begin bReq1 = req; bRw1 = rw; bAddr1 = addr; bWd1 = wdata; end
  endtask

  function automatic logic ackOf(input bit useB, input bit port);
    if (useB) return port ? bAck1 : bAck0;
    return port ? aAck1 : aAck0;
  endfunction

  // Counts clock edges until the expected ack shows, bounded so a missing ack still ends.
  task automatic awaitAck(input bit useB, input bit port, input int expEdges, input string tag);
    int  n;
    bit  seen;
    bit  other;
    n = 0;
    seen = 1'b0;
    other = 1'b0;
    while (!seen && n < expEdges + 4) begin
      tick();
      n++;
      if (ackOf(useB, port))  seen = 1'b1;
      if (ackOf(useB, !port)) other = 1'b1;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'(expEdges));
    checkOutput({tag, "_otherAck"}, 32'(other), 32'd0);
  endtask

  initial begin
    int w0;
    int idle0;
    int b1;
    int bw0;
    rst = 1'b1;
    preload = 1'b1;
    applyStimulus(0, 0, 0, 0, 12'd0, 32'd0);
    applyStimulus(0, 1, 0, 0, 12'd0, 32'd0);
    applyStimulus(1, 0, 0, 0, 12'd0, 32'd0);
    applyStimulus(1, 1, 0, 0, 12'd0, 32'd0);
    tick();
    tick();
    checkOutput("rst_busy",  32'(aBusy), 32'd0);
    checkOutput("rst_ack0",  32'(aAck0), 32'd0);
    checkOutput("rst_ack1",  32'(aAck1), 32'd0);
    checkOutput("rst_mrw",   32'(aMrw),  32'd0);
    checkOutput("rst_maddr", 32'(aMaddr), 32'd0);
    checkOutput("rst_mwd",   aMwd, 32'd0);
    checkOutput("rst_rd0",   aRd0, 32'd0);
    checkOutput("rst_rd1",   aRd1, 32'd0);
    checkOutput("rstB_busy", 32'(bBusy), 32'd0);
    rst = 1'b0;
    preload = 1'b0;
    tick();
    bw0 = bWrCnt;

    // Single read on port 0: ack four edges after the request is presented.
    w0 = aWrCnt;
    applyStimulus(0, 0, 1, 0, 12'd5, 32'd0);
    awaitAck(0, 0, 4, "t1");
    checkOutput("t1_rd0", aRd0, 32'hA5A5_0001);
    checkOutput("t1_rd1", aRd1, 32'd0);
    applyStimulus(0, 0, 0, 0, 12'd5, 32'd0);
    tick();
    checkOutput("t1_ackDone", 32'(aAck0), 32'd0);
    checkOutput("t1_idle", 32'(aBusy), 32'd0);
    checkOutput("t1_noWrite", 32'(aWrCnt - w0), 32'd0);

    // Port 1 write then port 0 read-back of the same word.
    applyStimulus(0, 1, 1, 1, 12'd9, 32'hDEAD_BEEF);
    awaitAck(0, 1, 4, "t2w");
    applyStimulus(0, 1, 0, 0, 12'd9, 32'd0);
    checkOutput("t2_wrPulses", 32'(aWrCnt - w0), 32'd1);
    checkOutput("t2_mem9", memA[9], 32'hDEAD_BEEF);
    checkOutput("t2_rd1Kept", aRd1, 32'd0);
    checkOutput("t2_rd0Kept", aRd0, 32'hA5A5_0001);
    tick();
    applyStimulus(0, 0, 1, 0, 12'd9, 32'd0);
    awaitAck(0, 0, 4, "t2r");
    checkOutput("t2_rd0", aRd0, 32'hDEAD_BEEF);
    checkOutput("t2_wrOnce", 32'(aWrCnt - w0), 32'd1);
    applyStimulus(0, 0, 0, 0, 12'd9, 32'd0);
    tick();

    // Reset lands in the final ACCESS cycle of a write: strobe drops, memory untouched.
    applyStimulus(0, 0, 1, 1, 12'd3, 32'hBAD0_BAD0);
    tick();
    tick();
    tick();
    checkOutput("t5_strobeBefore", 32'(aMrw), 32'd1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 12'd0, 32'd0);
    #1;
    checkOutput("t5_mrw", 32'(aMrw), 32'd0);
    checkOutput("t5_busy", 32'(aBusy), 32'd0);
    checkOutput("t5_maddr", 32'(aMaddr), 32'd0);
    checkOutput("t5_mwd", aMwd, 32'd0);
    checkOutput("t5_rd0", aRd0, 32'd0);
    tick();
    checkOutput("t5_mem3", memA[3], 32'h1111_2222);
    checkOutput("t5_noAck", 32'(aAck0), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("t5_stillIdle", 32'(aBusy), 32'd0);

    // Both ports held: round-robin alternates starting from port 0.
    applyStimulus(0, 0, 1, 0, 12'd5, 32'd0);
    applyStimulus(0, 1, 1, 0, 12'd9, 32'd0);
    awaitAck(0, 0, 4, "t3g0");
    checkOutput("t3_rd0", aRd0, 32'hA5A5_0001);
    idle0 = aIdleCnt;
    awaitAck(0, 1, 5, "t3g1");
    checkOutput("t3_rd1", aRd1, 32'hDEAD_BEEF);
    awaitAck(0, 0, 5, "t3g2");
    awaitAck(0, 1, 5, "t3g3");
    checkOutput("t3_idleGaps", 32'(aIdleCnt - idle0), 32'd3);
    applyStimulus(0, 0, 0, 0, 12'd0, 32'd0);
    applyStimulus(0, 1, 0, 0, 12'd0, 32'd0);
    tick();

    // Fixed priority, zero wait states: port 0 wins every time.
    b1 = bAck1Cnt;
    applyStimulus(1, 0, 1, 0, 12'd1, 32'd0);
    applyStimulus(1, 1, 1, 0, 12'd2, 32'd0);
    awaitAck(1, 0, 2, "t4g0");
    checkOutput("t4_rd0", bRd0, 32'h1000_0001);
    awaitAck(1, 0, 3, "t4g1");
    awaitAck(1, 0, 3, "t4g2");
    applyStimulus(1, 0, 0, 0, 12'd0, 32'd0);
    applyStimulus(1, 1, 0, 0, 12'd0, 32'd0);
    tick();
    checkOutput("t4_ack1Never", 32'(bAck1Cnt - b1), 32'd0);
    checkOutput("t4_rd1", bRd1, 32'd0);

    // Request dropped right after ACCESS entry still completes.
    applyStimulus(1, 0, 1, 0, 12'd0, 32'd0);
    tick();
    checkOutput("t6_busy", 32'(bBusy), 32'd1);
    applyStimulus(1, 0, 0, 0, 12'd0, 32'd0);
    awaitAck(1, 0, 1, "t6");
    checkOutput("t6_rd0", bRd0, 32'hC0FF_EE00);
    tick();
    checkOutput("t6_idle", 32'(bBusy), 32'd0);
    checkOutput("t6_ackDone", 32'(bAck0), 32'd0);
    checkOutput("tB_noWrites", 32'(bWrCnt - bw0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
